// File: rtl/nco_phase_acc.sv
// 24-bit NCO phase accumulator: tuning-word changes land on carry-out so the
// phase stays continuous, with optional LFSR dither ahead of 12-bit truncation.
module nco_phase_acc #(
  parameter int DITHER_EN = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [19:0] ftw_in,
  input  logic        ftw_ld,
  input  logic        ftw_upd,
  input  logic        phase_clr,
  output logic [11:0] phase_out,
  output logic        phase_vld,
  output logic        wrap,
  output logic        sweep_start
);

  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  // Fibonacci step for x^16+x^14+x^13+x^11+1, shifting toward the MSB.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  logic [23:0] acc_q, acc_d;
  logic [19:0] ftw_act_q, ftw_act_d;
  logic [19:0] ftw_pend_q, ftw_pend_d;
  logic        pend_q, pend_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic        ftw_upd_q;
  logic [11:0] phase_out_q, phase_out_d;
  logic        phase_vld_q;
  logic        wrap_q, wrap_d;
  logic        sweep_start_q;

  logic [24:0] sum_s;
  logic [23:0] dith_s;
  logic        add_s, carry_s, xfer_s;

  // Next-state: clear beats enable, and a pending word moves to active on carry-out or when idle.
  always_comb begin
    add_s       = en & ~phase_clr;
    sum_s       = {1'b0, acc_q} + {5'd0, ftw_act_q};
    carry_s     = add_s & sum_s[24];
    xfer_s      = pend_q & (carry_s | (ftw_act_q == 20'd0));
    dith_s      = acc_q + {12'd0, lfsr_q[11:0]};
    acc_d       = acc_q;
    ftw_act_d   = ftw_act_q;
    ftw_pend_d  = ftw_pend_q;
    pend_d      = pend_q;
    lfsr_d      = lfsr_q;
    phase_out_d = acc_q[23:12];
    wrap_d      = carry_s;

    if (phase_clr) begin
      acc_d = 24'd0;
    end else if (en) begin
      acc_d = sum_s[23:0];
    end else begin
      acc_d = acc_q;
    end

    if (xfer_s) begin
      ftw_act_d = ftw_pend_q;
    end else begin
      ftw_act_d = ftw_act_q;
    end

    if (ftw_ld) begin
      ftw_pend_d = ftw_in;
      pend_d     = 1'b1;
    end else if (xfer_s) begin
      pend_d     = 1'b0;
    end else begin
      pend_d     = pend_q;
    end

    if (en) begin
      lfsr_d = lfsr_step(lfsr_q);
    end else begin
      lfsr_d = lfsr_q;
    end

    if (DITHER_EN != 32'sd0) begin
      phase_out_d = dith_s[23:12];
    end else begin
      phase_out_d = acc_q[23:12];
    end
  end

  // State and output registers; reset discards any pending word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q         <= 24'd0;
      ftw_act_q     <= 20'd0;
      ftw_pend_q    <= 20'd0;
      pend_q        <= 1'b0;
      lfsr_q        <= LFSR_SEED;
      ftw_upd_q     <= 1'b0;
      phase_out_q   <= 12'd0;
      phase_vld_q   <= 1'b0;
      wrap_q        <= 1'b0;
      sweep_start_q <= 1'b0;
    end else begin
      acc_q         <= acc_d;
      ftw_act_q     <= ftw_act_d;
      ftw_pend_q    <= ftw_pend_d;
      pend_q        <= pend_d;
      lfsr_q        <= lfsr_d;
      ftw_upd_q     <= ftw_upd;
      phase_out_q   <= phase_out_d;
      phase_vld_q   <= en;
      wrap_q        <= wrap_d;
      sweep_start_q <= ftw_upd & ~ftw_upd_q;
    end
  end

  assign phase_out   = phase_out_q;
  assign phase_vld   = phase_vld_q;
  assign wrap        = wrap_q;
  assign sweep_start = sweep_start_q;

endmodule

// File: tb/tb_nco_phase_acc.sv
// Bench for nco_phase_acc: undithered and dithered instances share stimulus;
// a reference model feeds a scoreboard and directed checks use hand-computed values.
module tb_nco_phase_acc;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [19:0] ftw_in;
  logic        ftw_ld;
  logic        ftw_upd;
  logic        phase_clr;
  logic [11:0] phase0, phase1;
  logic        vld0, vld1, wrap0, wrap1, sweep0, sweep1;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [11:0] ph0;
    logic [11:0] ph1;
    logic        wr;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;

  logic [23:0] m_acc;
  logic [19:0] m_act, m_pend;
  logic        m_pflag;
  logic [15:0] m_lfsr;
  logic        m_vld;

  always #5 clk = ~clk;

  nco_phase_acc #(.DITHER_EN(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .en(en), .ftw_in(ftw_in), .ftw_ld(ftw_ld),
    .ftw_upd(ftw_upd), .phase_clr(phase_clr), .phase_out(phase0),
    .phase_vld(vld0), .wrap(wrap0), .sweep_start(sweep0)
  );

  nco_phase_acc #(.DITHER_EN(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .ftw_in(ftw_in), .ftw_ld(ftw_ld),
    .ftw_upd(ftw_upd), .phase_clr(phase_clr), .phase_out(phase1),
    .phase_vld(vld1), .wrap(wrap1), .sweep_start(sweep1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model for one rising edge; pushes the response the DUTs will present.
  task automatic model_edge();
    logic [24:0] sum;
    logic [23:0] dith;
    logic        carry, xfer, fb;
    exp_t        e;
    sum   = {1'b0, m_acc} + {5'd0, m_act};
    carry = en && !phase_clr && sum[24];
    dith  = m_acc + {12'd0, m_lfsr[11:0]};
    if (en) begin
      e.ph0 = m_acc[23:12];
      e.ph1 = dith[23:12];
      e.wr  = carry;
      sb_q.push_back(e);
    end
    m_vld = en;
    xfer  = m_pflag && (carry || (m_act == 20'd0));
    if (xfer) m_act = m_pend;
    if (ftw_ld) begin
      m_pend  = ftw_in;
      m_pflag = 1'b1;
    end else if (xfer) begin
      m_pflag = 1'b0;
    end
    if (phase_clr) m_acc = 24'd0;
    else if (en)   m_acc = sum[23:0];
    if (en) begin
      fb     = m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10];
      m_lfsr = {m_lfsr[14:0], fb};
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // Asserts reset away from any edge and checks outputs clear with no clock edge.
  task automatic do_reset();
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_phase_out", {8'd0, phase1, phase0}, 32'd0);
    check("rst_phase_vld", {30'd0, vld1, vld0}, 32'd0);
    check("rst_wrap", {30'd0, wrap1, wrap0}, 32'd0);
    check("rst_sweep_start", {30'd0, sweep1, sweep0}, 32'd0);
    m_acc = 24'd0; m_act = 20'd0; m_pend = 20'd0; m_pflag = 1'b0;
    m_lfsr = 16'hACE1; m_vld = 1'b0;
    sb_q.delete();
    en = 1'b0; ftw_ld = 1'b0; ftw_in = 20'd0; ftw_upd = 1'b0; phase_clr = 1'b0;
    #1;
    rst_n = 1'b1;
  endtask

  // Scoreboard monitor: pops one expected response whenever a DUT presents valid phase.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      check("phase_vld", {30'd0, vld1, vld0}, {30'd0, m_vld, m_vld});
      if (vld0 === 1'b1) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_underflow: got valid output, expected none at %0t", $time);
        end else begin
          mon_e = sb_q.pop_front();
          check("sb_phase_plain", {20'd0, phase0}, {20'd0, mon_e.ph0});
          check("sb_phase_dither", {20'd0, phase1}, {20'd0, mon_e.ph1});
          check("sb_wrap", {30'd0, wrap1, wrap0}, {30'd0, mon_e.wr, mon_e.wr});
        end
      end else begin
        check("idle_wrap", {30'd0, wrap1, wrap0}, 32'd0);
      end
    end
  end

  initial begin
    int   first;
    int   nwrap;
    int   npulse;
    logic upd_pat [9];
    logic sw_exp  [9];
    upd_pat = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    sw_exp  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    rst_n = 1'b0; en = 1'b0; ftw_in = 20'd0; ftw_ld = 1'b0; ftw_upd = 1'b0; phase_clr = 1'b0;
    do_reset();

    // Load 2796 from reset: first wrap on the 6001st add.
    en = 1'b1; ftw_in = 20'd2796; ftw_ld = 1'b1; tick();
    ftw_ld = 1'b0; tick();
    first = 0; nwrap = 0;
    for (int k = 1; k <= 6010; k++) begin
      tick();
      if (wrap0 === 1'b1) begin
        nwrap++;
        if (first == 0) first = k;
      end
      if (k == 10)   check("s29_phase_k10", {20'd0, phase0}, 32'd6);
      if (k == 6001) check("s29_phase_pre_wrap", {20'd0, phase0}, 32'd4095);
      if (k == 6002) check("s29_phase_post_wrap", {20'd0, phase0}, 32'd0);
    end
    check("s29_first_wrap_add", first, 32'd6001);
    check("s29_wrap_count", nwrap, 32'd1);

    // Async reset while running at 139270.
    do_reset();
    en = 1'b1; ftw_in = 20'd139270; ftw_ld = 1'b1; tick();
    ftw_ld = 1'b0; tick();
    for (int k = 1; k <= 10; k++) tick();
    check("s28_running_phase", {20'd0, phase0}, 32'd306);
    do_reset();

    // Retune mid-cycle: new word only after the carry-out add.
    en = 1'b1; ftw_in = 20'd139270; ftw_ld = 1'b1; tick();
    ftw_ld = 1'b0; tick();
    first = 0; nwrap = 0;
    for (int k = 1; k <= 130; k++) begin
      if (k == 50) begin
        ftw_in = 20'd2796;
        ftw_ld = 1'b1;
      end
      tick();
      ftw_ld = 1'b0;
      if (wrap0 === 1'b1) begin
        nwrap++;
        if (first == 0) first = k;
      end
      if (k == 121) check("s30_phase_pre_wrap", {20'd0, phase0}, 32'd4080);
      if (k == 123) check("s30_phase_new_word1", {20'd0, phase0}, 32'd18);
      if (k == 124) check("s30_phase_new_word2", {20'd0, phase0}, 32'd19);
    end
    check("s30_first_wrap_add", first, 32'd121);
    check("s30_wrap_count", nwrap, 32'd1);

    // Load coincident with an idle-rule transfer keeps the new word pending.
    do_reset();
    en = 1'b1; ftw_in = 20'd4096; ftw_ld = 1'b1; tick();
    ftw_in = 20'd8192; ftw_ld = 1'b1; tick();
    ftw_ld = 1'b0;
    first = 0; nwrap = 0;
    for (int k = 1; k <= 4100; k++) begin
      tick();
      if (wrap0 === 1'b1) begin
        nwrap++;
        if (first == 0) first = k;
      end
      if (k == 5)    check("s31_phase_old_word", {20'd0, phase0}, 32'd4);
      if (k == 4099) check("s31_phase_new_word", {20'd0, phase0}, 32'd4);
    end
    check("s31_first_wrap_add", first, 32'd4096);
    check("s31_wrap_count", nwrap, 32'd1);

    // Clear at acc=0xFFFF00 suppresses the carry that the add would produce.
    do_reset();
    en = 1'b1; ftw_in = 20'hFFFF0; ftw_ld = 1'b1; tick();
    ftw_ld = 1'b0; tick();
    for (int k = 1; k <= 16; k++) tick();
    phase_clr = 1'b1; tick();
    check("s32_clr_no_wrap", {31'd0, wrap0}, 32'd0);
    check("s32_clr_edge_phase", {20'd0, phase0}, 32'hFFF);
    phase_clr = 1'b0; tick();
    check("s32_phase_after_clr", {20'd0, phase0}, 32'd0);
    en = 1'b0; tick();
    check("s32_vld_low", {31'd0, vld0}, 32'd0);
    tick(); tick();
    en = 1'b1; tick();
    check("s32_phase_held", {20'd0, phase0}, 32'h0FF);
    tick(); tick();

    // Sweep-restart edge detect: high 3, low 2, high again.
    npulse = 0;
    for (int i = 0; i < 9; i++) begin
      ftw_upd = upd_pat[i];
      tick();
      check("s33_sweep_start", {30'd0, sweep1, sweep0}, {30'd0, sw_exp[i], sw_exp[i]});
      if (sweep0 === 1'b1) npulse++;
    end
    check("s33_pulse_count", npulse, 32'd2);

    en = 1'b0; ftw_upd = 1'b0;
    tick(); tick();
    check("sb_drained", sb_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/nco_phase_acc.md
NCO_PHASE_ACC -- requirements
Module: nco_phase_acc

Interface
REQ-001 SHALL have parameter DITHER_EN, default 1: 1 = LFSR phase dither before truncation; 0 = plain truncation.
REQ-002 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port en  input  1  accumulate enable.
REQ-005 SHALL have port ftw_in  input  20  frequency tuning word from the FM controller, unsigned.
REQ-006 SHALL have port ftw_ld  input  1  one-cycle strobe that captures ftw_in.
REQ-007 SHALL have port ftw_upd  input  1  sweep-restart level from the FM controller, high while the controller sits at LUT index 0.
REQ-008 SHALL have port phase_clr  input  1  synchronous accumulator clear.
REQ-009 SHALL have port phase_out  output  12  truncated phase to the sine LUT.
REQ-010 SHALL have port phase_vld  output  1  phase_out is valid.
REQ-011 SHALL have port wrap  output  1  one-cycle pulse on accumulator carry-out.
REQ-012 SHALL have port sweep_start  output  1  one-cycle pulse on ftw_upd rising edge.

Function
REQ-013 SHALL hold a 24-bit accumulator acc, a 20-bit active word ftw_act, a 20-bit pending word ftw_pend, and a pending flag pend.
REQ-014 SHALL, on each edge with en=1 and phase_clr=0, set acc <= (acc + zero-extended ftw_act) mod 2^24.
REQ-015 SHALL set wrap to 1 for exactly the edge following an add that produced carry-out; otherwise wrap is 0.
REQ-016 SHALL, on each edge with ftw_ld=1, set ftw_pend <= ftw_in and pend <= 1.
REQ-017 SHALL transfer ftw_pend to ftw_act and clear pend at the edge where pend=1 and either the current add carries out or ftw_act==0. This keeps frequency steps phase-continuous at cycle boundaries.
REQ-018 SHALL, when ftw_ld coincides with a transfer edge, transfer the old ftw_pend, capture ftw_in as the new ftw_pend, and leave pend=1.
REQ-019 SHALL, with phase_clr=1, set acc <= 0 at the next edge regardless of en; phase_clr does not affect ftw_act, ftw_pend, pend or the LFSR.
REQ-020 SHALL hold acc and the LFSR when en=0; pending transfers under the ftw_act==0 rule still occur.
REQ-021 SHALL implement a 16-bit Fibonacci LFSR, polynomial x^16+x^14+x^13+x^11+1, seed 16'hACE1, advancing one step per edge with en=1.
REQ-022 SHALL register phase_out <= ((acc + {12'b0, lfsr[11:0]}) mod 2^24)[23:12] when DITHER_EN=1, else acc[23:12]; latency is one clock after the acc update.
REQ-023 SHALL register phase_vld <= en, aligned with phase_out.
REQ-024 SHALL register ftw_upd into ftw_upd_d and drive sweep_start <= ftw_upd & ~ftw_upd_d; a held level yields one pulse only.
REQ-025 SHALL give phase_clr priority over en; a wrap pulse is never generated on a clear edge.

Reset
REQ-026 SHALL, while rst_n=0, force acc=0, ftw_act=0, ftw_pend=0, pend=0, lfsr=16'hACE1, ftw_upd_d=0, phase_out=0, phase_vld=0, wrap=0 and sweep_start=0, independent of clk.
REQ-027 SHALL resume operation on the first rising clk edge after rst_n deasserts; reset mid-operation discards any pending word.

Verification
REQ-028 Scenario: assert rst_n=0 mid-accumulation with ftw_act=139270 -> all outputs 0 immediately, with no clk edge needed.
REQ-029 Scenario: DITHER_EN=0, out of reset, ftw_in=2796 with ftw_ld pulse, en=1 -> ftw_act=2796 after one edge (ftw_act==0 rule); acc=2796*k after k adds; first wrap pulse after the 6001st add; phase_out=acc[23:12] one cycle later.
REQ-030 Scenario: ftw_act=139270 running, ftw_ld with 2796 between wraps -> adds keep using 139270 until the carry-out add, then use 2796 from the next add; acc stays phase-continuous.
REQ-031 Scenario: ftw_ld coincident with a transfer edge -> ftw_act gets the old pending value and pend remains 1 holding the new value.
REQ-032 Scenario: phase_clr=1 with en=1, acc=0xFFFF00 -> acc=0 next edge, phase_out=0 (DITHER_EN=0) following edge, no wrap pulse.
REQ-033 Scenario: ftw_upd high for 3 cycles, low 2, high again -> exactly two single-cycle sweep_start pulses, each one edge after its rising edge.
